// File: rtl/wb_commit_tracer.sv
// Commit trace buffer: captures one record per retired instruction from the WB stage
// into a first-word-fall-through FIFO drained over a valid/ready port; overflow is sticky and counted.
module wb_commit_tracer #(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [31:0]                wb_instr,
    input  logic [4:0]                 wb_rd,
    input  logic                       wb_regwrite,
    input  logic [31:0]                wb_result,
    input  logic                       trace_clr,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [31:0]                trace_instr,
    output logic [4:0]                 trace_rd,
    output logic                       trace_we,
    output logic [31:0]                trace_wdata,
    output logic [SEQ_W-1:0]           trace_seq,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [4:0]       rd_mem_q    [DEPTH];
    logic             we_mem_q    [DEPTH];
    logic [31:0]      wdata_mem_q [DEPTH];
    logic [SEQ_W-1:0] seq_mem_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic full_s, pop_s, push_s, drop_s, rec_we_s;

    // Next-state for pointers, occupancy, sequence and overflow accounting
    always_comb begin
        full_s     = (count_q == CNT_W'(DEPTH));
        pop_s      = (count_q != '0) && trace_ready;
        push_s     = wb_valid && !trace_clr && (!full_s || pop_s);
        drop_s     = wb_valid && !trace_clr && full_s && !pop_s;
        rec_we_s   = wb_regwrite && (wb_rd != 5'd0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        // Every retiring instruction consumes a sequence number, even when lost
        seq_d      = wb_valid ? (seq_q + SEQ_W'(1)) : seq_q;
        if (trace_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            drop_d     = (drop_q == {DROP_W{1'b1}}) ? drop_q : (drop_q + DROP_W'(1));
        end else begin
            overflow_d = overflow_q;
            drop_d     = drop_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Record storage; stale contents are never visible because outputs are masked when empty
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            instr_mem_q[wr_ptr_q] <= wb_instr;
            rd_mem_q[wr_ptr_q]    <= rec_we_s ? wb_rd : 5'd0;
            we_mem_q[wr_ptr_q]    <= rec_we_s;
            wdata_mem_q[wr_ptr_q] <= rec_we_s ? wb_result : 32'd0;
            seq_mem_q[wr_ptr_q]   <= seq_q;
        end
    end

    // Head presentation, driven only from registered state
    always_comb begin
        trace_valid = (count_q != '0);
        if (trace_valid) begin
            trace_instr = instr_mem_q[rd_ptr_q];
            trace_rd    = rd_mem_q[rd_ptr_q];
            trace_we    = we_mem_q[rd_ptr_q];
            trace_wdata = wdata_mem_q[rd_ptr_q];
            trace_seq   = seq_mem_q[rd_ptr_q];
        end else begin
            trace_instr = 32'd0;
            trace_rd    = 5'd0;
            trace_we    = 1'b0;
            trace_wdata = 32'd0;
            trace_seq   = '0;
        end
    end

    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
